axist_test_seq_ctrl: RTL and testbench

Management-clock sequencer that runs one AXI-ST over AIB loopback test end to end, through the axi_st_csr master port (address/writedata/write/read, waitrequest, readdatavalid).
- Sequence: program delay X/Y/Z, wait for link online, configure and start the pattern generator, poll checker status, stop the generator, report pass/fail.
- Replaces the testbench CSR write scripts, so the AIB top can self-test under a single start pulse.

---
 rtl/axist_seq_pkg.sv | 29 ++
 rtl/axist_csr_mstr_if.sv | 60 ++++++
 rtl/axist_test_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_axist_test_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axist_seq_pkg.sv
// axist_seq_pkg: CSR map, CFG word layout and state types for the AXI-ST loopback test sequencer
package axist_seq_pkg;
    localparam logic [31:0] ADDR_DELAY_X = 32'h0000_1000;
    localparam logic [31:0] ADDR_DELAY_Y = 32'h0000_1004;
    localparam logic [31:0] ADDR_DELAY_Z = 32'h0000_1008;
    localparam logic [31:0] ADDR_PATCFG  = 32'h0000_1010;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_1014;
    localparam int CFG_EN      = 0;
    localparam int CFG_SEL_LSB = 1;
    localparam int CFG_CNT_LSB = 3;
    localparam int CFG_CNTUS   = 12;
    typedef enum logic [3:0] {
        S_IDLE, S_WR_DX, S_WR_DY, S_WR_DZ, S_WAIT_ON, S_WR_CFG, S_WR_GO,
        S_GAP, S_RD_STAT, S_WAIT_RDV, S_EVAL, S_WR_STOP, S_DONE
    } seq_state_e;
    typedef enum logic [2:0] {
        ERR_NONE = 3'd0, ERR_ONLINE = 3'd1, ERR_POLL = 3'd2, ERR_RDV = 3'd3, ERR_LINK = 3'd4
    } err_code_e;
    function automatic logic [31:0] cfg_word(input logic en, input logic [1:0] sel,
                                             input logic [8:0] cnt, input logic cus);
        logic [31:0] w;
        w = '0;
        w[CFG_EN] = en;
        w[CFG_SEL_LSB +: 2] = sel;
        w[CFG_CNT_LSB +: 9] = cnt;
        w[CFG_CNTUS] = cus;
        return w;
    endfunction
endpackage

// File: rtl/axist_csr_mstr_if.sv
// axist_csr_mstr_if: single-outstanding CSR write/read handshake engine with readdatavalid timeout
module axist_csr_mstr_if #(
    parameter int RDV_TIMEOUT = 64
) (
    input  logic        mgmt_clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        rvalid,
    output logic        rd_timeout,
    output logic [31:0] rdata,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wrdata,
    output logic        o_wren,
    output logic        o_rden,
    input  logic [31:0] i_master_readdata,
    input  logic        i_master_readdatavalid,
    input  logic        i_master_waitreq
);
    localparam int CW = $clog2(RDV_TIMEOUT + 1);
    logic          wait_rdv;
    logic [CW-1:0] cnt;
    assign ack        = (o_wren | o_rden) & ~i_master_waitreq;
    assign rvalid     = wait_rdv & i_master_readdatavalid;
    assign rd_timeout = wait_rdv & ~i_master_readdatavalid & (cnt == CW'(RDV_TIMEOUT - 1));
    always_ff @(posedge mgmt_clk) begin
        if (rst) begin
            o_wren    <= 1'b0;
            o_rden    <= 1'b0;
            o_wr_addr <= '0;
            o_wrdata  <= '0;
            rdata     <= '0;
            wait_rdv  <= 1'b0;
            cnt       <= '0;
        end else begin
            if (ack) begin
                o_wren   <= 1'b0;
                o_rden   <= 1'b0;
                wait_rdv <= o_rden;
                cnt      <= '0;
            end else if (req && !o_wren && !o_rden && !wait_rdv) begin
                o_wren    <= we;
                o_rden    <= ~we;
                o_wr_addr <= addr;
                o_wrdata  <= wdata;
            end
            if (rvalid) begin
                rdata    <= i_master_readdata;
                wait_rdv <= 1'b0;
            end else if (rd_timeout) begin
                wait_rdv <= 1'b0;
            end else if (wait_rdv && cnt != CW'(RDV_TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/axist_test_seq_ctrl.sv
// axist_test_seq_ctrl: runs one AXI-ST over AIB loopback test through the CSR master port
module axist_test_seq_ctrl
    import axist_seq_pkg::*;
#(
    parameter int ONLINE_TIMEOUT = 65536,
    parameter int POLL_GAP       = 256,
    parameter int POLL_MAX       = 1024,
    parameter int RDV_TIMEOUT    = 64
) (
    input  logic        mgmt_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] cfg_delay_x,
    input  logic [31:0] cfg_delay_y,
    input  logic [31:0] cfg_delay_z,
    input  logic [1:0]  cfg_patgen_sel,
    input  logic [8:0]  cfg_patgen_cnt,
    input  logic        cfg_cntuspatt_en,
    input  logic        tx_online,
    input  logic        rx_online,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wrdata,
    output logic        o_wren,
    output logic        o_rden,
    input  logic [31:0] i_master_readdata,
    input  logic        i_master_readdatavalid,
    input  logic        i_master_waitreq,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code
);
    localparam int CMAX = (ONLINE_TIMEOUT > POLL_GAP) ? ONLINE_TIMEOUT : POLL_GAP;
    localparam int TW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL_MAX + 1);
    seq_state_e    state, state_n;
    err_code_e     err, err_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [PW-1:0] polls, polls_n;
    logic          pass_q, pass_n, lost, lost_n;
    logic [1:0]    tx_s, rx_s;
    logic          online_s, req, we, ack, rvalid, rd_timeout, stat_unused;
    logic [31:0]   addr, wdata, rdata;
    assign online_s    = tx_s[1] & rx_s[1];
    assign busy        = !(state inside {S_IDLE, S_DONE});
    assign done        = state == S_DONE;
    assign pass        = pass_q & (err == ERR_NONE);
    assign err_code    = err;
    assign stat_unused = ^rdata[31:2];
    axist_csr_mstr_if #(.RDV_TIMEOUT(RDV_TIMEOUT)) u_csr (
        .mgmt_clk(mgmt_clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rvalid(rvalid), .rd_timeout(rd_timeout), .rdata(rdata),
        .o_wr_addr(o_wr_addr), .o_wrdata(o_wrdata), .o_wren(o_wren), .o_rden(o_rden),
        .i_master_readdata(i_master_readdata), .i_master_readdatavalid(i_master_readdatavalid),
        .i_master_waitreq(i_master_waitreq)
    );
    always_ff @(posedge mgmt_clk) begin
        if (rst) begin
            tx_s   <= '0;
            rx_s   <= '0;
            state  <= S_IDLE;
            err    <= ERR_NONE;
            cnt    <= '0;
            polls  <= '0;
            pass_q <= 1'b0;
            lost   <= 1'b0;
        end else begin
            tx_s   <= {tx_s[0], tx_online};
            rx_s   <= {rx_s[0], rx_online};
            state  <= state_n;
            err    <= err_n;
            cnt    <= cnt_n;
            polls  <= polls_n;
            pass_q <= pass_n;
            lost   <= lost_n;
        end
    end
    always_comb begin
        state_n = state;
        err_n   = err;
        pass_n  = pass_q;
        polls_n = polls;
        cnt_n   = (cnt == TW'(CMAX)) ? cnt : cnt + 1'b1;
        lost_n  = lost | ((state inside {S_WR_GO, S_GAP, S_RD_STAT, S_WAIT_RDV, S_EVAL}) & ~online_s);
        req     = state inside {S_WR_DX, S_WR_DY, S_WR_DZ, S_WR_CFG, S_WR_GO, S_RD_STAT, S_WR_STOP};
        we      = state != S_RD_STAT;
        addr    = ADDR_PATCFG;
        wdata   = cfg_word(state == S_WR_GO, cfg_patgen_sel, cfg_patgen_cnt, cfg_cntuspatt_en);
        case (state)
            S_IDLE, S_DONE: if (start) begin
                state_n = S_WR_DX;
                err_n   = ERR_NONE;
                pass_n  = 1'b0;
                polls_n = '0;
                lost_n  = 1'b0;
            end
            S_WR_DX: begin
                addr  = ADDR_DELAY_X;
                wdata = cfg_delay_x;
                if (ack) state_n = S_WR_DY;
            end
            S_WR_DY: begin
                addr  = ADDR_DELAY_Y;
                wdata = cfg_delay_y;
                if (ack) state_n = S_WR_DZ;
            end
            S_WR_DZ: begin
                addr  = ADDR_DELAY_Z;
                wdata = cfg_delay_z;
                if (ack) begin
                    state_n = S_WAIT_ON;
                    cnt_n   = '0;
                end
            end
            S_WAIT_ON: if (online_s) begin
                state_n = S_WR_CFG;
            end else if (cnt == TW'(ONLINE_TIMEOUT - 1)) begin
                err_n   = ERR_ONLINE;
                state_n = S_DONE;
            end
            S_WR_CFG: if (ack) state_n = S_WR_GO;
            S_WR_GO: if (ack) begin
                state_n = S_GAP;
                cnt_n   = '0;
            end
            S_GAP: if (lost_n) begin
                err_n   = ERR_LINK;
                state_n = S_WR_STOP;
            end else if (cnt == TW'(POLL_GAP - 1)) begin
                state_n = S_RD_STAT;
            end
            S_RD_STAT: begin
                addr = ADDR_STATUS;
                if (ack) state_n = S_WAIT_RDV;
            end
            S_WAIT_RDV: if (rvalid) begin
                state_n = S_EVAL;
            end else if (rd_timeout) begin
                err_n   = ERR_RDV;
                state_n = S_WR_STOP;
            end
            S_EVAL: if (lost_n) begin
                err_n   = ERR_LINK;
                state_n = S_WR_STOP;
            end else if (rdata[0]) begin
                pass_n  = rdata[1];
                state_n = S_WR_STOP;
            end else if (polls == PW'(POLL_MAX)) begin
                err_n   = ERR_POLL;
                state_n = S_WR_STOP;
            end else begin
                polls_n = polls + 1'b1;
                cnt_n   = '0;
                state_n = S_GAP;
            end
            S_WR_STOP: if (ack) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axist_test_seq_ctrl.sv
// tb_axist_test_seq_ctrl: directed scenarios against a negedge-driven CSR slave model
module tb_axist_test_seq_ctrl;
    localparam logic [31:0] AX = 32'h0000_1000, AY = 32'h0000_1004, AZ = 32'h0000_1008;
    localparam logic [31:0] AC = 32'h0000_1010;
    localparam logic [31:0] DX = 32'hA5A5_0001, DY = 32'h5A5A_0002, DZ = 32'h1234_0003;
    logic        mgmt_clk, rst, start, cfg_cntuspatt_en, tx_online, rx_online;
    logic [31:0] cfg_delay_x, cfg_delay_y, cfg_delay_z, o_wr_addr, o_wrdata, rdin;
    logic [1:0]  cfg_patgen_sel;
    logic [8:0]  cfg_patgen_cnt;
    logic        o_wren, o_rden, rdv, waitreq, busy, done, pass;
    logic [2:0]  err_code;
    logic [31:0] stat [8];
    logic [31:0] wa [32];
    logic [31:0] wd [32];
    logic [31:0] hold_data, ha, hd;
    int total, bad, nwr, nrd, sidx, pend, hold_left, held_ok;
    logic h_seen, rdv_en;

    axist_test_seq_ctrl #(.ONLINE_TIMEOUT(100), .POLL_GAP(4), .POLL_MAX(3), .RDV_TIMEOUT(8)) dut (
        .mgmt_clk(mgmt_clk), .rst(rst), .start(start),
        .cfg_delay_x(cfg_delay_x), .cfg_delay_y(cfg_delay_y), .cfg_delay_z(cfg_delay_z),
        .cfg_patgen_sel(cfg_patgen_sel), .cfg_patgen_cnt(cfg_patgen_cnt),
        .cfg_cntuspatt_en(cfg_cntuspatt_en), .tx_online(tx_online), .rx_online(rx_online),
        .o_wr_addr(o_wr_addr), .o_wrdata(o_wrdata), .o_wren(o_wren), .o_rden(o_rden),
        .i_master_readdata(rdin), .i_master_readdatavalid(rdv), .i_master_waitreq(waitreq),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code)
    );

    initial mgmt_clk = 1'b0;
    always #5 mgmt_clk = ~mgmt_clk;

    // CSR slave: decides waitreq, logs accepted writes/reads, returns status two cycles after a read
    initial begin
        waitreq = 1'b0;
        rdv = 1'b0;
        rdin = '0;
        forever begin
            @(negedge mgmt_clk);
            rdv = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    rdv = 1'b1;
                    rdin = stat[sidx < 7 ? sidx : 7];
                    sidx++;
                end
            end
            if (o_wren && o_wrdata == hold_data && hold_left > 0) begin
                if (!h_seen) begin
                    ha = o_wr_addr;
                    hd = o_wrdata;
                    h_seen = 1'b1;
                end
                if (o_wr_addr == ha && o_wrdata == hd) held_ok++;
                hold_left--;
                waitreq = 1'b1;
            end else begin
                waitreq = 1'b0;
            end
            if (o_wren && !waitreq && nwr < 32) begin
                wa[nwr] = o_wr_addr;
                wd[nwr] = o_wrdata;
                nwr++;
            end
            if (o_rden && !waitreq) begin
                nrd++;
                if (rdv_en) pend = 2;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mgmt_clk);
            #1;
        end
    endtask

    task automatic prep(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2, input logic en);
        stat[0] = s0;
        stat[1] = s1;
        for (int i = 2; i < 8; i++) stat[i] = s2;
        sidx = 0; nwr = 0; nrd = 0; pend = 0;
        hold_left = 0; held_ok = 0; h_seen = 1'b0; hold_data = '0;
        rdv_en = en;
    endtask

    task automatic pulse_start();
        @(posedge mgmt_clk);
        #1 start = 1'b1;
        @(posedge mgmt_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        total += 7;
        if (done !== 1'b0) begin $display("FAIL reset_done got=%b want=0", done); bad++; end
        if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); bad++; end
        if (pass !== 1'b0) begin $display("FAIL reset_pass got=%b want=0", pass); bad++; end
        if (err_code !== 3'd0) begin $display("FAIL reset_err got=%0d want=0", err_code); bad++; end
        if (o_wren !== 1'b0) begin $display("FAIL reset_wren got=%b want=0", o_wren); bad++; end
        if (o_rden !== 1'b0) begin $display("FAIL reset_rden got=%b want=0", o_rden); bad++; end
        if (o_wr_addr !== 32'd0) begin $display("FAIL reset_addr got=%h want=0", o_wr_addr); bad++; end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_nominal();
        logic [31:0] ea [6];
        logic [31:0] ed [6];
        int n;
        ea = '{AX, AY, AZ, AC, AC, AC};
        ed = '{DX, DY, DZ, 32'h322, 32'h323, 32'h322};
        tx_online = 1'b0; rx_online = 1'b0;
        prep(32'h0, 32'h0, 32'h3, 1'b1);
        pulse_start();
        total += 2;
        if (busy !== 1'b1) begin $display("FAIL nom_busy got=%b want=1", busy); bad++; end
        if (done !== 1'b0) begin $display("FAIL nom_notdone got=%b want=0", done); bad++; end
        cyc(20);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(29);
        tx_online = 1'b1; rx_online = 1'b1;
        wait_done(1000, n);
        total += 6;
        if (done !== 1'b1) begin $display("FAIL nom_done got=%b want=1", done); bad++; end
        if (nwr !== 6) begin $display("FAIL nom_nwr got=%0d want=6", nwr); bad++; end
        if (nrd !== 3) begin $display("FAIL nom_nrd got=%0d want=3", nrd); bad++; end
        if (pass !== 1'b1) begin $display("FAIL nom_pass got=%b want=1", pass); bad++; end
        if (err_code !== 3'd0) begin $display("FAIL nom_err got=%0d want=0", err_code); bad++; end
        if (busy !== 1'b0) begin $display("FAIL nom_idle got=%b want=0", busy); bad++; end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i])
                begin $display("FAIL nom_wr%0d got=%h/%h want=%h/%h", i, wa[i], wd[i], ea[i], ed[i]); bad++; end
        end
        cyc(10);
        total += 2;
        if (done !== 1'b1 || pass !== 1'b1) begin $display("FAIL nom_hold got=%b%b want=11", done, pass); bad++; end
        if (nwr !== 6) begin $display("FAIL nom_quiet got=%0d want=6", nwr); bad++; end
    endtask

    task automatic test_chk_fail();
        int n;
        prep(32'h1, 32'h1, 32'h1, 1'b1);
        pulse_start();
        total++;
        if (done !== 1'b0) begin $display("FAIL chk_clear got=%b want=0", done); bad++; end
        wait_done(1000, n);
        total += 5;
        if (done !== 1'b1) begin $display("FAIL chk_done got=%b want=1", done); bad++; end
        if (pass !== 1'b0) begin $display("FAIL chk_pass got=%b want=0", pass); bad++; end
        if (err_code !== 3'd0) begin $display("FAIL chk_err got=%0d want=0", err_code); bad++; end
        if (nwr !== 6) begin $display("FAIL chk_nwr got=%0d want=6", nwr); bad++; end
        if (wa[5] !== AC || wd[5] !== 32'h322) begin $display("FAIL chk_stop got=%h/%h want=%h/322", wa[5], wd[5], AC); bad++; end
    endtask

    task automatic test_online_to();
        int n;
        tx_online = 1'b0; rx_online = 1'b0;
        prep(32'h3, 32'h3, 32'h3, 1'b1);
        pulse_start();
        wait_done(1000, n);
        total += 5;
        if (done !== 1'b1) begin $display("FAIL onl_done got=%b want=1", done); bad++; end
        if (err_code !== 3'd1) begin $display("FAIL onl_err got=%0d want=1", err_code); bad++; end
        if (pass !== 1'b0) begin $display("FAIL onl_pass got=%b want=0", pass); bad++; end
        if (nwr !== 3) begin $display("FAIL onl_nwr got=%0d want=3", nwr); bad++; end
        if (n < 100 || n > 115) begin $display("FAIL onl_time got=%0d want=100..115", n); bad++; end
        tx_online = 1'b1; rx_online = 1'b1;
        cyc(3);
    endtask

    task automatic test_waitreq_hold();
        int n, c;
        cfg_patgen_sel = 2'd2; cfg_patgen_cnt = 9'd5; cfg_cntuspatt_en = 1'b1;
        prep(32'h3, 32'h3, 32'h3, 1'b1);
        hold_data = 32'h102C;
        hold_left = 20;
        pulse_start();
        wait_done(1000, n);
        c = 0;
        for (int i = 0; i < nwr; i++) if (wd[i] == 32'h102C) c++;
        total += 6;
        if (held_ok !== 20) begin $display("FAIL hold_stable got=%0d want=20", held_ok); bad++; end
        if (nwr !== 6) begin $display("FAIL hold_nwr got=%0d want=6", nwr); bad++; end
        if (c !== 2) begin $display("FAIL hold_cfgcnt got=%0d want=2", c); bad++; end
        if (wd[4] !== 32'h102D) begin $display("FAIL hold_go got=%h want=102d", wd[4]); bad++; end
        if (pass !== 1'b1) begin $display("FAIL hold_pass got=%b want=1", pass); bad++; end
        if (err_code !== 3'd0) begin $display("FAIL hold_err got=%0d want=0", err_code); bad++; end
        cfg_patgen_sel = 2'd1; cfg_patgen_cnt = 9'd100; cfg_cntuspatt_en = 1'b0;
    endtask

    task automatic test_rdv_to();
        int n;
        prep(32'h3, 32'h3, 32'h3, 1'b0);
        pulse_start();
        wait_done(1000, n);
        total += 5;
        if (err_code !== 3'd3) begin $display("FAIL rdv_err got=%0d want=3", err_code); bad++; end
        if (pass !== 1'b0) begin $display("FAIL rdv_pass got=%b want=0", pass); bad++; end
        if (nrd !== 1) begin $display("FAIL rdv_nrd got=%0d want=1", nrd); bad++; end
        if (nwr !== 6) begin $display("FAIL rdv_nwr got=%0d want=6", nwr); bad++; end
        if (wa[5] !== AC || wd[5] !== 32'h322) begin $display("FAIL rdv_stop got=%h/%h want=%h/322", wa[5], wd[5], AC); bad++; end
    endtask

    task automatic test_poll_to();
        int n;
        prep(32'h0, 32'h0, 32'h0, 1'b1);
        pulse_start();
        wait_done(2000, n);
        total += 4;
        if (err_code !== 3'd2) begin $display("FAIL poll_err got=%0d want=2", err_code); bad++; end
        if (nrd !== 4) begin $display("FAIL poll_nrd got=%0d want=4", nrd); bad++; end
        if (nwr !== 6) begin $display("FAIL poll_nwr got=%0d want=6", nwr); bad++; end
        if (pass !== 1'b0) begin $display("FAIL poll_pass got=%b want=0", pass); bad++; end
    endtask

    task automatic test_link_lost();
        int n;
        prep(32'h0, 32'h0, 32'h0, 1'b1);
        pulse_start();
        n = 0;
        while (nwr < 5 && n < 500) begin cyc(1); n++; end
        total++;
        if (nwr < 5) begin $display("FAIL link_go got=%0d want=5", nwr); bad++; end
        cyc(2);
        rx_online = 1'b0;
        wait_done(1000, n);
        total += 4;
        if (err_code !== 3'd4) begin $display("FAIL link_err got=%0d want=4", err_code); bad++; end
        if (nwr !== 6) begin $display("FAIL link_nwr got=%0d want=6", nwr); bad++; end
        if (wa[5] !== AC || wd[5] !== 32'h322) begin $display("FAIL link_stop got=%h/%h want=%h/322", wa[5], wd[5], AC); bad++; end
        if (pass !== 1'b0) begin $display("FAIL link_pass got=%b want=0", pass); bad++; end
        rx_online = 1'b1;
        cyc(3);
    endtask

    task automatic test_rst_mid();
        int n;
        prep(32'h3, 32'h3, 32'h3, 1'b1);
        hold_data = 32'h323;
        hold_left = 1000;
        pulse_start();
        n = 0;
        while (!(o_wren && o_wrdata == 32'h323) && n < 500) begin cyc(1); n++; end
        cyc(2);
        total++;
        if (o_wren !== 1'b1) begin $display("FAIL rst_go_held got=%b want=1", o_wren); bad++; end
        rst = 1'b1;
        cyc(1);
        total += 6;
        if (o_wren !== 1'b0) begin $display("FAIL rst_wren got=%b want=0", o_wren); bad++; end
        if (o_rden !== 1'b0) begin $display("FAIL rst_rden got=%b want=0", o_rden); bad++; end
        if ({o_wr_addr, o_wrdata} !== 64'd0) begin $display("FAIL rst_bus got=%h/%h want=0/0", o_wr_addr, o_wrdata); bad++; end
        if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b want=0", busy); bad++; end
        if (done !== 1'b0) begin $display("FAIL rst_done got=%b want=0", done); bad++; end
        if ({pass, err_code} !== 4'd0) begin $display("FAIL rst_status got=%b/%0d want=0/0", pass, err_code); bad++; end
        rst = 1'b0;
        hold_left = 0;
        n = nwr;
        cyc(10);
        total += 2;
        if (busy !== 1'b0 || o_wren !== 1'b0) begin $display("FAIL rst_idle got=%b%b want=00", busy, o_wren); bad++; end
        if (nwr !== n) begin $display("FAIL rst_nocompl got=%0d want=%0d", nwr, n); bad++; end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0;
        cfg_delay_x = DX; cfg_delay_y = DY; cfg_delay_z = DZ;
        cfg_patgen_sel = 2'd1; cfg_patgen_cnt = 9'd100; cfg_cntuspatt_en = 1'b0;
        tx_online = 1'b0; rx_online = 1'b0;
        prep(32'h0, 32'h0, 32'h0, 1'b1);
        test_reset();
        test_nominal();
        test_chk_fail();
        test_online_to();
        test_waitreq_hold();
        test_rdv_to();
        test_poll_to();
        test_link_lost();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
